// File: rtl/epf_error_monitor.sv
// rtl/epf_error_monitor.sv - PAM4 symbol error monitor with good/error burst tracking and indexed stats readout
module epf_error_monitor #(
    parameter int HIST_BINS = 16,
    parameter int CNT_W     = 48,
    parameter int LEN_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  symbol_ref,
    input  logic [1:0]  symbol_rx,
    input  logic        clear,
    input  logic [31:0] rd_idx,
    output logic [63:0] rd_data,
    output logic        in_burst,
    output logic        err_pulse
);
    localparam int HW = $clog2(HIST_BINS);

    typedef enum logic {GOOD, ERR} state_t;

    state_t             state, state_nx;
    logic [1:0]         diff;
    logic               is_err, take, close_burst, open_burst;
    logic [CNT_W-1:0]   sym_cnt, err_cnt, burst_cnt, err_after_err;
    logic [CNT_W-1:0]   plus_cnt, minus_cnt, big_cnt;
    logic [CNT_W-1:0]   hist [HIST_BINS];
    logic [LEN_W-1:0]   burst_len, max_burst;
    logic [HW-1:0]      bin;
    logic [63:0]        rd_mux;

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Modulo-4 wrap makes ref=3/rx=0 a plus error.
    assign diff   = symbol_rx - symbol_ref;
    assign is_err = (diff != 2'd0);
    assign take   = en && !clear;
    assign bin    = (burst_len >= LEN_W'(HIST_BINS - 1)) ? HW'(HIST_BINS - 1) : burst_len[HW-1:0];
    assign in_burst = (state == ERR);

    always_comb begin
        state_nx    = state;
        close_burst = 1'b0;
        open_burst  = 1'b0;
        if (take) begin
            case (state)
                GOOD: if (is_err) begin
                    state_nx   = ERR;
                    open_burst = 1'b1;
                end
                ERR: if (!is_err) begin
                    state_nx    = GOOD;
                    close_burst = 1'b1;
                end
                default: state_nx = GOOD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) state <= GOOD;
        else              state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sym_cnt       <= '0;
            err_cnt       <= '0;
            burst_cnt     <= '0;
            err_after_err <= '0;
            plus_cnt      <= '0;
            minus_cnt     <= '0;
            big_cnt       <= '0;
            burst_len     <= '0;
            max_burst     <= '0;
            err_pulse     <= 1'b0;
            for (int k = 0; k < HIST_BINS; k++) hist[k] <= '0;
        end else begin
            err_pulse <= take && is_err;
            if (take) begin
                sym_cnt <= sat_cnt(sym_cnt);
                if (is_err) err_cnt <= sat_cnt(err_cnt);
                case (diff)
                    2'd1:    plus_cnt  <= sat_cnt(plus_cnt);
                    2'd2:    big_cnt   <= sat_cnt(big_cnt);
                    2'd3:    minus_cnt <= sat_cnt(minus_cnt);
                    default: ;
                endcase
                if (open_burst) begin
                    burst_cnt <= sat_cnt(burst_cnt);
                    burst_len <= LEN_W'(1);
                end else if (state == ERR && is_err) begin
                    err_after_err <= sat_cnt(err_after_err);
                    burst_len     <= sat_len(burst_len);
                end
                // The closing sample bins the burst in the same edge that returns to GOOD.
                if (close_burst) begin
                    hist[bin] <= sat_cnt(hist[bin]);
                    if (burst_len > max_burst) max_burst <= burst_len;
                    burst_len <= '0;
                end
            end
        end
    end

    always_comb begin
        rd_mux = 64'd0;
        case (rd_idx)
            32'd0:   rd_mux = 64'(sym_cnt);
            32'd1:   rd_mux = 64'(err_cnt);
            32'd2:   rd_mux = 64'(burst_cnt);
            32'd3:   rd_mux = 64'(err_after_err);
            32'd4:   rd_mux = 64'(plus_cnt);
            32'd5:   rd_mux = 64'(minus_cnt);
            32'd6:   rd_mux = 64'(big_cnt);
            32'd7:   rd_mux = 64'(max_burst);
            32'd8:   rd_mux = 64'(burst_len);
            default: ;
        endcase
        for (int k = 0; k < HIST_BINS; k++)
            if (rd_idx == 32'(16 + k)) rd_mux = 64'(hist[k]);
    end

    always_ff @(posedge clk) begin
        if (rst) rd_data <= 64'd0;
        else     rd_data <= rd_mux;
    end
endmodule

// File: tb/tb_epf_error_monitor.sv
// tb/tb_epf_error_monitor.sv - randomized self-checking bench for epf_error_monitor against a statistics model
module tb_epf_error_monitor;
    logic        clk = 1'b0;
    logic        rst, en, clear;
    logic [1:0]  symbol_ref, symbol_rx;
    logic [31:0] rd_idx;
    logic [63:0] rd_data;
    logic        in_burst, err_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    epf_error_monitor #(.HIST_BINS(16), .CNT_W(48), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .symbol_ref(symbol_ref), .symbol_rx(symbol_rx),
        .clear(clear), .rd_idx(rd_idx), .rd_data(rd_data), .in_burst(in_burst), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    // Statistics model: plain counts kept per the classification and burst rules.
    longint m_sym, m_err, m_burst, m_eae, m_plus, m_minus, m_big, m_max, m_len;
    longint m_hist [16];
    bit     m_in_err, m_pulse;

    function automatic void model_clear();
        m_sym = 0; m_err = 0; m_burst = 0; m_eae = 0; m_plus = 0; m_minus = 0; m_big = 0;
        m_max = 0; m_len = 0; m_in_err = 0; m_pulse = 0;
        for (int k = 0; k < 16; k++) m_hist[k] = 0;
    endfunction

    function automatic void model_step(input bit e, input bit c, input logic [1:0] r, input logic [1:0] x);
        int d;
        d = (int'(x) - int'(r) + 4) % 4;
        m_pulse = 0;
        if (c) begin model_clear(); return; end
        if (!e) return;
        m_sym++;
        if (d != 0) begin
            m_err++;
            m_pulse = 1;
            if (d == 1) m_plus++;
            else if (d == 3) m_minus++;
            else m_big++;
            if (m_in_err) begin m_eae++; m_len++; end
            else begin m_in_err = 1; m_burst++; m_len = 1; end
        end else if (m_in_err) begin
            m_hist[(m_len > 15) ? 15 : m_len]++;
            if (m_len > m_max) m_max = m_len;
            m_len = 0;
            m_in_err = 0;
        end
    endfunction

    function automatic longint exp_reg(input int idx);
        case (idx)
            0: return m_sym;   1: return m_err;   2: return m_burst; 3: return m_eae;
            4: return m_plus;  5: return m_minus; 6: return m_big;   7: return m_max;
            8: return m_len;
            default: return (idx >= 16 && idx < 32) ? m_hist[idx-16] : 0;
        endcase
    endfunction

    task automatic send(input bit e, input bit c, input logic [1:0] r, input logic [1:0] x);
        @(negedge clk);
        en = e; clear = c; symbol_ref = r; symbol_rx = x;
        model_step(e, c, r, x);
    endtask

    task automatic rd(input int idx, output logic [63:0] v);
        @(negedge clk);
        en = 0; clear = 0; rd_idx = idx;
        m_pulse = 0;
        @(negedge clk);
        v = rd_data;
    endtask

    task automatic do_clear();
        send(0, 1, 2'd0, 2'd0);
    endtask

    task automatic test_reset();
        logic [63:0] v;
        @(negedge clk);
        rst = 1; en = 0; clear = 0; rd_idx = 0; symbol_ref = 0; symbol_rx = 0;
        model_clear();
        repeat (2) @(negedge clk);
        n_checks++;
        if (rd_data !== 64'd0 || in_burst !== 1'b0 || err_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: rd_data=%0d in_burst=%b err_pulse=%b, required 0/0/0", rd_data, in_burst, err_pulse);
        end
        rst = 0;
        for (int k = 0; k < 33; k++) begin
            rd(k, v);
            n_checks++;
            if (v !== 64'd0) begin n_fail++; $display("FAIL reset_reg%0d: got %0d required 0", k, v); end
        end
    endtask

    task automatic test_correct();
        logic [63:0] v;
        bit seen = 0;
        do_clear();
        for (int i = 0; i < 100; i++) begin
            send(1, 0, 2'(i), 2'(i));
            @(posedge clk); #1;
            if (in_burst) seen = 1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL correct_in_burst: saw 1 required never high"); end
        rd(0, v); n_checks++;
        if (v !== 64'd100) begin n_fail++; $display("FAIL correct_sym: got %0d required 100", v); end
        for (int k = 1; k < 32; k++) begin
            if (k == 9) k = 16;
            rd(k, v); n_checks++;
            if (v !== 64'd0) begin n_fail++; $display("FAIL correct_reg%0d: got %0d required 0", k, v); end
        end
    endtask

    task automatic test_isolated();
        logic [63:0] v;
        logic [63:0] req [8];
        do_clear();
        for (int i = 0; i < 30; i++) begin
            if (i == 10)      send(1, 0, 2'd2, 2'd3);
            else if (i == 20) send(1, 0, 2'd3, 2'd0);
            else              send(1, 0, 2'(i), 2'(i));
        end
        req = '{64'd1, 64'd2, 64'd2, 64'd0, 64'd2, 64'd0, 64'd0, 64'd1};
        for (int k = 1; k < 8; k++) begin
            rd(k, v); n_checks++;
            if (v !== req[k]) begin n_fail++; $display("FAIL isolated_reg%0d: got %0d required %0d", k, v, req[k]); end
        end
        rd(17, v); n_checks++;
        if (v !== 64'd2) begin n_fail++; $display("FAIL isolated_hist1: got %0d required 2", v); end
    endtask

    task automatic test_burst5();
        logic [63:0] v;
        do_clear();
        send(1, 0, 2'd0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            send(1, 0, 2'd1, (i % 2 == 0) ? 2'd2 : 2'd0);
            if (i == 2) begin
                rd(8, v); n_checks++;
                if (v !== 64'd3) begin n_fail++; $display("FAIL burst5_midlen: got %0d required 3", v); end
            end
        end
        send(1, 0, 2'd1, 2'd1);
        rd(8, v);  n_checks++; if (v !== 64'd0) begin n_fail++; $display("FAIL burst5_len_after: got %0d required 0", v); end
        rd(21, v); n_checks++; if (v !== 64'd1) begin n_fail++; $display("FAIL burst5_hist5: got %0d required 1", v); end
        rd(3, v);  n_checks++; if (v !== 64'd4) begin n_fail++; $display("FAIL burst5_eae: got %0d required 4", v); end
        rd(4, v);  n_checks++; if (v !== 64'd3) begin n_fail++; $display("FAIL burst5_plus: got %0d required 3", v); end
        rd(5, v);  n_checks++; if (v !== 64'd2) begin n_fail++; $display("FAIL burst5_minus: got %0d required 2", v); end
        rd(7, v);  n_checks++; if (v !== 64'd5) begin n_fail++; $display("FAIL burst5_max: got %0d required 5", v); end
    endtask

    task automatic test_long_burst();
        logic [63:0] v;
        do_clear();
        for (int i = 0; i < 20; i++) begin
            if (i == 7) send(1, 0, 2'd0, 2'd2);
            else        send(1, 0, 2'(i), 2'(i + 1));
        end
        send(1, 0, 2'd3, 2'd3);
        rd(31, v); n_checks++; if (v !== 64'd1)  begin n_fail++; $display("FAIL long_hist15: got %0d required 1", v); end
        rd(7, v);  n_checks++; if (v !== 64'd20) begin n_fail++; $display("FAIL long_max: got %0d required 20", v); end
        rd(2, v);  n_checks++; if (v !== 64'd1)  begin n_fail++; $display("FAIL long_bursts: got %0d required 1", v); end
        rd(6, v);  n_checks++; if (v !== 64'd1)  begin n_fail++; $display("FAIL long_big: got %0d required 1", v); end
        rd(19, v); n_checks++; if (v !== 64'd0)  begin n_fail++; $display("FAIL long_hist3: got %0d required 0", v); end
    endtask

    task automatic test_clear_open();
        logic [63:0] v;
        do_clear();
        for (int i = 0; i < 3; i++) send(1, 0, 2'd1, 2'd2);
        send(1, 1, 2'd0, 2'd3);
        @(posedge clk); #1;
        n_checks++;
        if (in_burst !== 1'b0 || err_pulse !== 1'b0) begin
            n_fail++; $display("FAIL clear_flags: in_burst=%b err_pulse=%b required 0/0", in_burst, err_pulse);
        end
        for (int k = 0; k < 32; k++) begin
            rd(k, v); n_checks++;
            if (v !== 64'd0) begin n_fail++; $display("FAIL clear_reg%0d: got %0d required 0", k, v); end
        end
        send(1, 0, 2'd2, 2'd2);
        rd(0, v); n_checks++; if (v !== 64'd1) begin n_fail++; $display("FAIL clear_sym: got %0d required 1", v); end
        for (int k = 16; k < 32; k++) begin
            rd(k, v); n_checks++;
            if (v !== 64'd0) begin n_fail++; $display("FAIL clear_hist%0d: got %0d required 0", k - 16, v); end
        end
    endtask

    task automatic test_rst_midburst();
        logic [63:0] v;
        for (int i = 0; i < 4; i++) send(1, 0, 2'd0, 2'd3);
        @(negedge clk);
        rst = 1; en = 0;
        @(negedge clk);
        rst = 0;
        model_clear();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (in_burst !== 1'b0) begin n_fail++; $display("FAIL rst_in_burst: got %b required 0", in_burst); end
        end
        for (int k = 0; k < 32; k++) begin
            rd(k, v); n_checks++;
            if (v !== 64'd0) begin n_fail++; $display("FAIL rst_reg%0d: got %0d required 0", k, v); end
        end
        send(1, 0, 2'd1, 2'd1);
        send(1, 0, 2'd2, 2'd2);
        rd(40, v); n_checks++;
        if (v !== 64'd0) begin n_fail++; $display("FAIL rd_idx40: got %0d required 0", v); end
        @(negedge clk);
        rd_idx = 0;
        #1;
        n_checks++;
        if (rd_data !== 64'd0) begin n_fail++; $display("FAIL rd_latency_old: got %0d required 0", rd_data); end
        @(negedge clk);
        n_checks++;
        if (rd_data !== 64'd2) begin n_fail++; $display("FAIL rd_latency_new: got %0d required 2", rd_data); end
    endtask

    task automatic test_random();
        logic [63:0] v;
        logic [1:0]  r, x;
        bit          e, c;
        do_clear();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            n_checks++;
            if (in_burst !== m_in_err || err_pulse !== m_pulse) begin
                n_fail++;
                $display("FAIL rand_flags@%0d: in_burst=%b err_pulse=%b required %b/%b", i, in_burst, err_pulse, m_in_err, m_pulse);
            end
            r = 2'($urandom_range(0, 3));
            x = ($urandom_range(0, 9) < 4) ? 2'(r + 2'($urandom_range(1, 3))) : r;
            e = ($urandom_range(0, 7) != 0);
            c = ($urandom_range(0, 199) == 0);
            en = e; clear = c; symbol_ref = r; symbol_rx = x;
            model_step(e, c, r, x);
            if (i % 150 == 149) begin
                for (int k = 0; k < 33; k++) begin
                    rd(k, v); n_checks++;
                    if (v !== 64'(exp_reg(k))) begin
                        n_fail++; $display("FAIL rand_reg%0d: got %0d required %0d", k, v, exp_reg(k));
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1; en = 0; clear = 0; rd_idx = 0; symbol_ref = 0; symbol_rx = 0;
        model_clear();
        test_reset();
        test_correct();
        test_isolated();
        test_burst5();
        test_long_burst();
        test_clear_open();
        test_rst_midburst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
